sd_fifo_rx_burst_filler: RTL

// Parametrised successor of the SD RX FIFO filler. Buffers data words from the SD data path in an

---
 rtl/sd_pkg.sv | 19 +
 rtl/sd_sync_fifo.sv | 56 +++++
 rtl/sd_fifo_rx_burst_filler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD RX FIFO burst filler: Wishbone B3 cycle-type
// codes and the filler state encoding.
package sd_pkg;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Encoding is visible on the dbg_state port, keep values stable.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_BURST = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/sd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count and a
// synchronous flush. The caller is responsible for gating push/pop against
// full/empty.
module sd_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] cnt;

    // Pointer and occupancy bookkeeping; flush wins over any push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + LW'(push) - LW'(pop);
        end
    end

    // Storage array; a push while full-and-popping lands in the slot being
    // read out this same cycle, which is safe because the read is combinational.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/sd_fifo_rx_burst_filler.sv
// SD RX FIFO filler: buffers words from the SD data path and writes them to
// memory as a Wishbone B3 master using incrementing bursts, with a
// programmable transfer length and sticky overflow / bus-error reporting.
module sd_fifo_rx_burst_filler
    import sd_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [AW-1:0]          adr,
    input  logic [CNT_W-1:0]       xfer_words,
    input  logic [DW-1:0]          dat_i,
    input  logic                   wr,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   done,
    output logic                   bus_err,
    output logic [AW-1:0]          m_wb_adr_o,
    output logic [DW-1:0]          m_wb_dat_o,
    output logic [DW/8-1:0]        m_wb_sel_o,
    output logic                   m_wb_we_o,
    output logic                   m_wb_cyc_o,
    output logic                   m_wb_stb_o,
    output logic [2:0]             m_wb_cti_o,
    output logic [1:0]             m_wb_bte_o,
    input  logic                   m_wb_ack_i,
    input  logic                   m_wb_err_i,
    output logic [2:0]             dbg_state
);

    localparam int NW   = $clog2(BURST_LEN) + 1;
    localparam int STEP = DW / 8;

    // Bus handshake: a beat is transferred on any rising edge where cyc&stb
    // and ack are high; err in the same cycle overrides ack and the beat is
    // not consumed. Beats follow back to back inside one burst.

    state_t state, state_nxt;

    logic [AW-1:0]    base_q;
    logic [AW-1:0]    offset_q;
    logic [AW-1:0]    adr_q;
    logic [CNT_W-1:0] xfer_q;
    logic [CNT_W-1:0] acked_q;
    logic [CNT_W-1:0] remain;
    logic [NW-1:0]    n_calc;
    logic [NW-1:0]    burst_n_q;
    logic [NW-1:0]    beat_q;
    logic             ovf_q;
    logic             err_q;

    logic [DW-1:0]    head;
    logic             push;
    logic             pop;
    logic             flush;
    logic             busy;
    logic             last_beat;
    logic             beat_err;
    logic             level_ok;

    assign flush     = !en;
    assign busy      = (state == ST_BURST);
    assign beat_err  = busy && m_wb_err_i;
    assign pop       = busy && m_wb_ack_i && !m_wb_err_i && en;
    assign push      = wr && (!full || pop);
    assign last_beat = (beat_q == burst_n_q - NW'(1));
    assign level_ok  = (int'(level) >= int'(n_calc));

    sd_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (dat_i),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Size of the next burst: a full burst unless the transfer is nearly
    // complete; an unlimited transfer (length 0) always uses full bursts.
    always_comb begin
        remain = xfer_q - acked_q;
        if (xfer_q == '0)
            n_calc = NW'(BURST_LEN);
        else if (remain >= CNT_W'(BURST_LEN))
            n_calc = NW'(BURST_LEN);
        else
            n_calc = NW'(remain);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic; dropping en aborts from anywhere.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (n_calc == '0)  state_nxt = ST_DONE;
                    else if (level_ok) state_nxt = ST_BURST;
                end
                ST_BURST: begin
                    if (m_wb_err_i)                   state_nxt = ST_ERR;
                    else if (m_wb_ack_i && last_beat) state_nxt = ST_WAIT;
                end
                ST_DONE:  state_nxt = ST_DONE;
                ST_ERR:   state_nxt = ST_ERR;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Address, transfer counters and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q    <= '0;
            offset_q  <= '0;
            adr_q     <= '0;
            xfer_q    <= '0;
            acked_q   <= '0;
            burst_n_q <= '0;
            beat_q    <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else if (!en) begin
            offset_q <= '0;
            adr_q    <= base_q;
            acked_q  <= '0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                base_q   <= adr;
                xfer_q   <= xfer_words;
                offset_q <= '0;
                adr_q    <= adr;
                acked_q  <= '0;
                err_q    <= 1'b0;
            end
            if (state == ST_WAIT && n_calc != '0 && level_ok) begin
                burst_n_q <= n_calc;
                beat_q    <= '0;
            end
            if (pop) begin
                offset_q <= offset_q + AW'(STEP);
                adr_q    <= base_q + offset_q + AW'(STEP);
                acked_q  <= acked_q + CNT_W'(1);
                beat_q   <= beat_q + NW'(1);
            end
            if (beat_err) err_q <= 1'b1;
            if (state == ST_IDLE)              ovf_q <= 1'b0;
            else if (wr && full && !pop)       ovf_q <= 1'b1;
        end
    end

    // Bus and status outputs decoded from the current state.
    always_comb begin
        m_wb_cyc_o = busy;
        m_wb_stb_o = busy;
        m_wb_we_o  = busy;
        m_wb_sel_o = busy ? '1 : '0;
        m_wb_dat_o = busy ? head : '0;
        m_wb_cti_o = WB_CTI_CLASSIC;
        if (busy && burst_n_q != NW'(1))
            m_wb_cti_o = last_beat ? WB_CTI_EOB : WB_CTI_INCR;
        done = (state == ST_DONE);
    end

    assign m_wb_adr_o = adr_q;
    assign m_wb_bte_o = WB_BTE_LINEAR;
    assign overflow   = ovf_q;
    assign bus_err    = err_q;
    assign dbg_state  = state;

endmodule
